// File: rtl/chip1_pkg.sv
// Shared definitions for the chip1 dot-product sequencer: state encoding and
// the operand/accumulator widths of the 8x8+16 MAC it drives.
package chip1_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned ACC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage : chip1_pkg

// File: rtl/chip1_dot_sequencer.sv
// Dot-product sequencer for an external y = a*b + c MAC.
// Accepts a job (len, bias), streams len operand pairs over in_valid/in_ready,
// accumulates through the MAC (acc feeds mac_c, mac_y writes back to acc) and
// presents the 16-bit sum plus a sticky wrap flag over res_valid/res_ready.
// Ports:
//   clk, reset             clock, async active-low reset
//   start, len, bias       job request (sampled in IDLE only)
//   abort                  synchronous cancel, beats start/accept/handshake
//   busy                   high outside IDLE
//   in_valid/in_ready      operand handshake, in_a/in_b operands
//   mac_a/mac_b/mac_c      MAC inputs, mac_y MAC result (combinational)
//   res_valid/res_ready    result handshake, res_data/res_ovf result
module chip1_dot_sequencer
    import chip1_pkg::*;
#(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned MAC_W = ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [MAC_W-1:0] bias,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic [MAC_W-1:0] mac_c,
    input  logic [MAC_W-1:0] mac_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [MAC_W-1:0] res_data,
    output logic             res_ovf
);

    state_e             state_q, state_d;
    logic [MAC_W-1:0]   acc_q,   acc_d;
    logic [LEN_W-1:0]   cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and handshake/MAC-operand decode
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        busy      = 1'b0;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        mac_a     = '0;
        mac_b     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    acc_d = bias;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                mac_a    = in_a;
                mac_b    = in_b;
                if (abort) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (in_valid) begin
                    acc_d = mac_y;
                    // A product never exceeds 2**16, so a smaller sum means one wrap
                    ovf_d = ovf_q | (mac_y < acc_q);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Accumulator drives both the MAC addend and the result bus
    assign mac_c    = acc_q;
    assign res_data = acc_q;
    assign res_ovf  = ovf_q;

endmodule : chip1_dot_sequencer

// File: tb/tb_chip1_dot_sequencer.sv
// Directed self-checking bench for chip1_dot_sequencer with a behavioural MAC.
module tb_chip1_dot_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic [15:0] bias;
    logic        abort;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic [15:0] mac_c;
    logic [15:0] mac_y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    int pa [8];
    int pb [8];

    chip1_dot_sequencer #(.LEN_W(8), .MAC_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .abort     (abort),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_y     (mac_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf)
    );

    // Behavioural 8x8+16 MAC
    assign mac_y = 16'(16'(mac_a) * 16'(mac_b)) + mac_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one job, feeding pa/pb on handshake with 'gap' idle cycles after
    // each accept; pokes a stray start at loop iteration 'poke'; holds
    // res_ready low for 'bp' cycles, then retires the result.
    task automatic run_job(input string tag, input int n, input logic [15:0] b0,
                           input int gap, input int bp, input int poke,
                           input int exp_lat, input logic [15:0] exp_data,
                           input logic exp_ovf, input bit exp_ready_seen);
        int idx = 0;
        int gcnt = 0;
        int lat;
        int iter = 0;
        bit acc;
        bit ready_seen = 0;
        start = 1'b1; len = 8'(n); bias = b0;
        cyc();
        start = 1'b0; len = '0; bias = '0;
        lat = 1;
        #1;
        while (!res_valid && lat < 200) begin
            start = (iter == poke);
            len   = (iter == poke) ? 8'd1 : 8'd0;
            bias  = (iter == poke) ? 16'hAAAA : 16'h0;
            in_valid = (idx < n) && (gcnt == 0);
            in_a = (idx < n) ? 8'(pa[idx]) : 8'h0;
            in_b = (idx < n) ? 8'(pb[idx]) : 8'h0;
            #1;
            if (in_ready) ready_seen = 1;
            acc = in_valid && in_ready;
            cyc();
            start = 1'b0;
            if (acc) begin idx++; gcnt = gap; end
            else if (gcnt > 0) gcnt--;
            lat++;
            iter++;
            #1;
        end
        in_valid = 1'b0; in_a = '0; in_b = '0;
        check({tag, "_res_valid"}, res_valid, 1'b1);
        if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_ready_seen"}, ready_seen, exp_ready_seen);
        for (int k = 0; k < bp; k++) begin
            check({tag, "_hold_data"}, res_data, exp_data);
            cyc();
        end
        check({tag, "_data"}, res_data, exp_data);
        check({tag, "_ovf"}, res_ovf, exp_ovf);
        check({tag, "_hold_valid"}, res_valid, 1'b1);
        check({tag, "_hold_inready"}, in_ready, 1'b0);
        check({tag, "_hold_maca"}, mac_a, 8'h0);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        #1;
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_valid_after"}, res_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; len = '0; bias = '0; abort = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 16'h0);
        check("rst_res_ovf", res_ovf, 1'b0);
        check("rst_mac_c", mac_c, 16'h0);
        #11 reset = 1'b1;
        cyc();

        // Basic: 5 + 12 + 100 + 10 = 127, four edges from start to result
        pa[0] = 3; pb[0] = 4; pa[1] = 10; pb[1] = 10; pa[2] = 2; pb[2] = 5;
        run_job("basic", 3, 16'd5, 0, 0, -1, 4, 16'd127, 1'b0, 1'b1);

        // Zero length: result is the bias, next cycle
        run_job("zero", 0, 16'h1234, 0, 0, -1, 1, 16'h1234, 1'b0, 1'b0);

        // Stall and backpressure: 65025 + 1
        pa[0] = 255; pb[0] = 255; pa[1] = 1; pb[1] = 1;
        run_job("stall", 2, 16'd0, 3, 5, -1, 6, 16'd65026, 1'b0, 1'b1);

        // Overflow: 0xFFF0 + 0xFE01 = 0x1FDF1 -> 0xFDF1, +1 = 0xFDF2
        run_job("ovf", 2, 16'hFFF0, 0, 0, -1, 3, 16'hFDF2, 1'b1, 1'b1);
        pa[0] = 2; pb[0] = 3;
        run_job("ovf_clr", 1, 16'd0, 0, 0, -1, 2, 16'd6, 1'b0, 1'b1);

        // Stray start during RUN is ignored: 2 + 2 + 12 + 30 = 46
        pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 5; pb[2] = 6;
        run_job("poke", 3, 16'd2, 0, 0, 1, 4, 16'd46, 1'b0, 1'b1);

        // Abort after two accepts, with a pair still valid
        start = 1'b1; len = 8'd4; bias = 16'd9;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
        cyc();
        cyc();
        #1;
        check("abort_mid_acc", mac_c, 16'd11);
        abort = 1'b1;
        cyc();
        abort = 1'b0; in_valid = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_acc", res_data, 16'h0);
        for (int k = 0; k < 3; k++) begin
            check("abort_no_result", res_valid, 1'b0);
            cyc();
        end

        // Abort in IDLE beats start
        start = 1'b1; abort = 1'b1; len = 8'd2; bias = 16'd7;
        cyc();
        start = 1'b0; abort = 1'b0;
        #1;
        check("abort_idle_busy", busy, 1'b0);
        check("abort_idle_acc", mac_c, 16'h0);

        // Async reset mid-RUN
        start = 1'b1; len = 8'd3; bias = 16'd7;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5;
        cyc();
        #1;
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("areset_busy", busy, 1'b0);
        check("areset_in_ready", in_ready, 1'b0);
        check("areset_mac_a", mac_a, 8'h0);
        check("areset_mac_c", mac_c, 16'h0);
        check("areset_res_data", res_data, 16'h0);
        in_valid = 1'b0; in_a = '0; in_b = '0;
        @(negedge clk);
        reset = 1'b1;
        cyc();
        pa[0] = 2; pb[0] = 2;
        run_job("post_reset", 1, 16'd1, 0, 0, -1, 2, 16'd5, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_chip1_dot_sequencer
